uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_fsm

Overview:
- Serial receive side of the team's UART link; the counterpart of the transmit FSM.
- Recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) from the asynchronous rx line.
- Uses 16x oversampling with mid-bit sampling.
- Presents each received byte on a parallel bus with a valid/ack handshake, plus framing-error and overrun flags.

Parameters:
- CLK_DIV, 27, clk cycles per oversample tick (50 MHz / (115200 x 16)); legal range 1 to 65535.
- OVS, 16, oversample ticks per bit; fixed at 16, power of two.
- DATA_BITS, 8, data bits per frame; fixed at 8.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx  in  1  serial input; idles high; asynchronous to clk
- ack  in  1  consumer accepts dataout; single-cycle pulse or level
- dataout  out  8  last received byte, LSB = first data bit on the line
- valid  out  1  dataout holds an unconsumed byte
- frame_err  out  1  stop bit sampled low on the last frame; sticky until the next good frame
- overrun  out  1  a new byte completed while valid=1; sticky until ack
- busy  out  1  high from start-bit detect until the stop-bit sample

Behaviour:
- Reset (asynchronous, active-high) values: dataout=0, valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, all counters 0, synchroniser flops=1.
- Synchroniser: rx passes through 2 flops (rx_s) before any use. That adds 2 clk of latency.
- Tick generator:
  - A free-running counter runs 0..CLK_DIV-1 and pulses os_tick for 1 clk at wrap.
  - It is never reset except by reset.
- FSM advances only on os_tick cycles. States:
  - IDLE: busy=0, os_cnt=0. rx_s==0 -> START.
  - START: os_cnt increments each tick. At os_cnt==7 (mid start bit):
    - rx_s==0 -> DATA, with os_cnt=0 and bit_cnt=0.
    - rx_s==1 -> glitch; return to IDLE with no flags changed.
  - DATA: at os_cnt==15, sample rx_s into shift register bit [bit_cnt] (LSB first), then bit_cnt++.
    - When bit_cnt reaches 7 and is sampled -> STOP.
    - os_cnt wraps 15 -> 0.
  - STOP: at os_cnt==15, sample the stop bit.
    - Sample 1: commit the byte, frame_err<=0.
    - Sample 0: frame_err<=1, byte discarded, dataout/valid unchanged.
    - Either case -> IDLE in that same cycle. busy drops with the state change.
  - A frame ending low leaves rx_s low, so IDLE re-enters START on the next tick. The glitch check filters this.
- Commit, in the cycle of the stop sample:
  - dataout<=shift.
  - If valid==1 and no same-cycle ack: overrun<=1.
  - valid<=1 in all cases.
  - The newest byte always overwrites dataout.
- Handshake:
  - ack while valid=1 -> valid<=0 and overrun<=0 in the next clk.
  - ack while valid=0 is ignored.
  - Commit and ack in the same clk: commit wins. valid stays 1, dataout=new byte, overrun not set.
- Latency: valid rises at the stop-bit mid-sample, 9.5 bit times after the start edge, plus the 2-clk synchroniser delay and up to 1 os_tick of phase.
- Widths: os_cnt 4 bits, bit_cnt 3 bits, CLK_DIV counter 16 bits. All counters wrap with no saturation.
- Reset mid-frame: the partial byte is dropped. No valid or flag is raised until a fresh start bit arrives after reset deasserts.
- rx held low indefinitely (break):
  - Each frame ends with frame_err=1 and returns to IDLE.
  - The receiver retries every ~9.5 bits.
  - valid is never set during the break.

Decomposition:
- Shared package uart_pkg, holding:
  - RX state encodings: IDLE=0, START=1, DATA=2, STOP=3, as 2-bit constants.
  - OVS=16 and the mid-sample constants MID_START=7, SAMPLE_PT=15.
  - Default CLK_DIV for 115200 at 50 MHz. The transmit side uses the same value.
- Sub-module uart_os_tick_gen:
  - Parameter: CLK_DIV.
  - Ports: clk, reset, os_tick.
  - Reusable by the transmitter for 16x-accurate bit timing.
- The synchroniser stays inline.

Test Plan:
- Use CLK_DIV=4 to shorten simulation.
- Good frame: send 0xA5 (line 0,1,0,1,0,0,1,0,1,1), no ack -> valid=1, dataout=0xA5, frame_err=0, overrun=0. Then ack=1 for 1 clk -> valid=0 next clk.
- Glitch: rx low for 3 os_ticks then high -> state returns to IDLE, valid stays 0, busy pulses then drops.
- Framing error: send 0x3C with stop bit=0 -> frame_err=1, valid=0, dataout unchanged. Then send good 0x55 -> dataout=0x55, valid=1, frame_err=0.
- Overrun and collision:
  - Send 0x11 then 0x22 with no ack -> dataout=0x22, valid=1, overrun=1; ack clears both.
  - Repeat with ack asserted exactly in the 0x22 commit clk -> overrun=0, valid=1, dataout=0x22.
- Reset mid-frame: assert reset during data bit 4 of 0xFF -> all outputs go to 0 immediately. Release reset, send 0x0F -> dataout=0x0F with no stale bits.
- Back-to-back and baud tolerance: 16 random bytes with zero idle between frames and ±3% bit-period skew -> all 16 bytes received in order with ack each time, and no frame_err/overrun.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int OVS       = 16;
  localparam int DATA_BITS = 8;

  localparam logic [3:0] MID_START = 4'd7;
  localparam logic [3:0] SAMPLE_PT = 4'd15;

  // 50 MHz / (115200 * 16), shared with the transmit side
  localparam int DEFAULT_CLK_DIV = 27;

endpackage

// File: rtl/uart_rx_fsm_if.sv
// rtl/uart_rx_fsm_if.sv - serial input and parallel byte handshake of the UART receiver
interface uart_rx_fsm_if;

  logic       rx;
  logic       ack;
  logic [7:0] dataout;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx, ack,
    input  dataout, valid, frame_err, overrun, busy
  );

  modport slave (
    input  rx, ack,
    output dataout, valid, frame_err, overrun, busy
  );

endinterface

// File: rtl/uart_os_tick_gen.sv
// rtl/uart_os_tick_gen.sv - free-running divider producing the 16x oversample tick
module uart_os_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic os_tick
);

  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

  logic [15:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign os_tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - 8N1 UART receiver with 16x oversampling and valid/ack byte output
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic         clk,
  input  logic         reset,
  uart_rx_fsm_if.slave bus
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic os_tick;

  uart_os_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .os_tick (os_tick)
  );

  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  rx_state_t            state, state_n;
  logic [3:0]           os_cnt, os_cnt_n;
  logic [2:0]           bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] dataout, dataout_n;
  logic                 valid, valid_n;
  logic                 frame_err, frame_err_n;
  logic                 overrun, overrun_n;
  logic                 commit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RX_IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      dataout   <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      os_cnt    <= os_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      dataout   <= dataout_n;
      valid     <= valid_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
    end
  end

  always_comb begin
    state_n     = state;
    os_cnt_n    = os_cnt;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    dataout_n   = dataout;
    valid_n     = valid;
    frame_err_n = frame_err;
    overrun_n   = overrun;
    commit      = 1'b0;

    if (os_tick) begin
      case (state)
        RX_IDLE: begin
          os_cnt_n = '0;
          if (!rx_s) state_n = RX_START;
        end
        RX_START: begin
          // a start bit that is high again at its middle was only a glitch
          if (os_cnt == MID_START) begin
            os_cnt_n  = '0;
            bit_cnt_n = '0;
            state_n   = rx_s ? RX_IDLE : RX_DATA;
          end else begin
            os_cnt_n = os_cnt + 4'd1;
          end
        end
        RX_DATA: begin
          os_cnt_n = os_cnt + 4'd1;
          if (os_cnt == SAMPLE_PT) begin
            shift_n[bit_cnt] = rx_s;
            bit_cnt_n        = bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) state_n = RX_STOP;
          end
        end
        RX_STOP: begin
          os_cnt_n = os_cnt + 4'd1;
          if (os_cnt == SAMPLE_PT) begin
            state_n = RX_IDLE;
            if (rx_s) commit = 1'b1;
            else      frame_err_n = 1'b1;
          end
        end
        default: state_n = RX_IDLE;
      endcase
    end

    // a commit beats a same-cycle ack; that ack only keeps overrun from being set
    if (commit) begin
      dataout_n   = shift;
      valid_n     = 1'b1;
      frame_err_n = 1'b0;
      if (valid) overrun_n = !bus.ack;
    end else if (bus.ack && valid) begin
      valid_n   = 1'b0;
      overrun_n = 1'b0;
    end
  end

  assign bus.dataout   = dataout;
  assign bus.valid     = valid;
  assign bus.frame_err = frame_err;
  assign bus.overrun   = overrun;
  assign bus.busy      = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - randomized and directed bench for uart_rx_fsm against an event-level model
module tb_uart_rx_fsm;

  localparam int CLK_DIV     = 4;
  localparam int BIT_CLKS    = CLK_DIV * 16;
  localparam int FRAME_TICKS = 152;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_rx_fsm_if bus ();

  uart_rx_fsm #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_BUSY_UP, EV_BUSY_DN, EV_GOOD, EV_BAD} ev_kind_t;
  typedef struct {
    int         cyc;
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t  evq[$];
  int   cyc = 0;
  logic ack_q = 1'b0;
  int   ack_at = -1;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   m_commits = 0;

  logic [7:0] m_dataout;
  logic       m_valid, m_ferr, m_ovr, m_busy;

  // cyc counts posedges since reset release; ticks land on multiples of CLK_DIV
  always @(posedge clk) begin
    cyc   <= reset ? 0 : cyc + 1;
    ack_q <= bus.ack;
  end

  function automatic int next_tick(input int c);
    return ((c + CLK_DIV - 1) / CLK_DIV) * CLK_DIV;
  endfunction

  initial begin : model_cmp
    logic       good, bad;
    logic [7:0] nb;
    m_dataout = '0; m_valid = 0; m_ferr = 0; m_ovr = 0; m_busy = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_dataout = '0; m_valid = 0; m_ferr = 0; m_ovr = 0; m_busy = 0;
        evq.delete();
      end else begin
        good = 0; bad = 0; nb = '0;
        for (int i = evq.size() - 1; i >= 0; i--) begin
          if (evq[i].cyc == cyc) begin
            case (evq[i].kind)
              EV_BUSY_UP: m_busy = 1;
              EV_BUSY_DN: m_busy = 0;
              EV_GOOD:    begin good = 1; nb = evq[i].data; end
              default:    bad = 1;
            endcase
            evq.delete(i);
          end
        end
        if (good) begin
          if (m_valid) m_ovr = !ack_q;
          m_valid   = 1;
          m_dataout = nb;
          m_ferr    = 0;
          m_commits++;
        end else begin
          if (bad) m_ferr = 1;
          if (ack_q && m_valid) begin
            m_valid = 0;
            m_ovr   = 0;
          end
        end
        n_cmp++;
        if ({bus.dataout, bus.valid, bus.frame_err, bus.overrun, bus.busy} !==
            {m_dataout, m_valid, m_ferr, m_ovr, m_busy}) begin
          n_fail++;
          $display("FAIL cycle_%0d outputs: got data=%h valid=%b ferr=%b ovr=%b busy=%b, want data=%h valid=%b ferr=%b ovr=%b busy=%b",
                   cyc, bus.dataout, bus.valid, bus.frame_err, bus.overrun, bus.busy,
                   m_dataout, m_valid, m_ferr, m_ovr, m_busy);
        end
      end
    end
  end

  task automatic check_lit(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // flags packed as {valid, frame_err, overrun, busy}
  task automatic expect_state(input string tag, input logic [7:0] d, input logic [3:0] f);
    #1;
    check_lit({tag, "_data"}, bus.dataout, d);
    check_lit({tag, "_flags"}, {4'b0, bus.valid, bus.frame_err, bus.overrun, bus.busy}, {4'b0, f});
    check_lit({tag, "_mdata"}, m_dataout, d);
    check_lit({tag, "_mflags"}, {4'b0, m_valid, m_ferr, m_ovr, m_busy}, {4'b0, f});
  endtask

  task automatic step(input logic v);
    bus.rx  = v;
    bus.ack = (ack_at >= 0) && (cyc + 1 == ack_at);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1);
  endtask

  task automatic pulse_ack(input string tag);
    ack_at = cyc + 1;
    step(1'b1);
    #1;
    check_lit({tag, "_ack_valid"}, {7'b0, bus.valid}, 8'h00);
  endtask

  // ack_mode: 0 none, 1 in the commit clock, 2 a few clocks after commit
  task automatic send_frame(input logic [7:0] b, input logic stop, input int period, input int ack_mode);
    int         m, t0, p;
    logic [9:0] bits;
    m  = cyc;
    t0 = next_tick(m + 3);
    p  = t0 + FRAME_TICKS * CLK_DIV;
    evq.push_back(ev_t'{t0, EV_BUSY_UP, 8'h00});
    evq.push_back(ev_t'{p, EV_BUSY_DN, 8'h00});
    evq.push_back(ev_t'{p, stop ? EV_GOOD : EV_BAD, b});
    if (!stop) begin
      // line still low after a bad stop: one retry that the glitch check rejects
      evq.push_back(ev_t'{p + CLK_DIV, EV_BUSY_UP, 8'h00});
      evq.push_back(ev_t'{p + 9 * CLK_DIV, EV_BUSY_DN, 8'h00});
    end
    if (ack_mode == 1)      ack_at = p;
    else if (ack_mode == 2) ack_at = p + int'($urandom_range(1, 5));
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) repeat (period) step(bits[i]);
  endtask

  task automatic send_glitch();
    int m, t0;
    m  = cyc;
    t0 = next_tick(m + 3);
    evq.push_back(ev_t'{t0, EV_BUSY_UP, 8'h00});
    evq.push_back(ev_t'{t0 + 8 * CLK_DIV, EV_BUSY_DN, 8'h00});
    repeat (3 * CLK_DIV) step(1'b0);
  endtask

  task automatic reset_mid_frame();
    int m;
    m = cyc;
    evq.push_back(ev_t'{next_tick(m + 3), EV_BUSY_UP, 8'h00});
    repeat (BIT_CLKS) step(1'b0);
    repeat (4 * BIT_CLKS + BIT_CLKS / 2) step(1'b1);
    ack_at = -1;
    #3 reset = 1'b1;
    #1;
    check_lit("rstmid_data", bus.dataout, 8'h00);
    check_lit("rstmid_flags", {4'b0, bus.valid, bus.frame_err, bus.overrun, bus.busy}, 8'h00);
    repeat (4) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : stim
    int         c0;
    logic [7:0] rb;
    int         per;
    bus.rx  = 1'b1;
    bus.ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_lit("reset_data", bus.dataout, 8'h00);
    check_lit("reset_flags", {4'b0, bus.valid, bus.frame_err, bus.overrun, bus.busy}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    idle(BIT_CLKS);

    send_frame(8'hA5, 1'b1, BIT_CLKS, 0);
    idle(32);
    expect_state("good_a5", 8'hA5, 4'b1000);
    pulse_ack("good_a5");
    idle(BIT_CLKS);

    send_glitch();
    idle(BIT_CLKS);
    expect_state("glitch", 8'hA5, 4'b0000);

    send_frame(8'h3C, 1'b0, BIT_CLKS, 0);
    idle(2 * BIT_CLKS);
    expect_state("ferr_3c", 8'hA5, 4'b0100);
    send_frame(8'h55, 1'b1, BIT_CLKS, 0);
    idle(32);
    expect_state("good_55", 8'h55, 4'b1000);
    pulse_ack("good_55");
    idle(BIT_CLKS);

    send_frame(8'h11, 1'b1, BIT_CLKS, 0);
    send_frame(8'h22, 1'b1, BIT_CLKS, 0);
    idle(32);
    expect_state("overrun", 8'h22, 4'b1010);
    pulse_ack("overrun");
    expect_state("overrun_ack", 8'h22, 4'b0000);
    idle(BIT_CLKS);

    send_frame(8'h11, 1'b1, BIT_CLKS, 0);
    send_frame(8'h22, 1'b1, BIT_CLKS, 1);
    idle(32);
    expect_state("collide", 8'h22, 4'b1000);

    reset_mid_frame();
    idle(2 * BIT_CLKS);
    expect_state("post_reset", 8'h00, 4'b0000);
    send_frame(8'h0F, 1'b1, BIT_CLKS, 0);
    idle(32);
    expect_state("good_0f", 8'h0F, 4'b1000);
    pulse_ack("good_0f");
    idle(BIT_CLKS);

    c0 = m_commits;
    for (int i = 0; i < 16; i++) begin
      rb  = 8'($urandom);
      per = int'($urandom_range(BIT_CLKS - 2, BIT_CLKS + 2));
      send_frame(rb, 1'b1, per, 2);
    end
    idle(2 * BIT_CLKS);
    #1;
    check_lit("b2b_count", 8'(m_commits - c0), 8'd16);
    check_lit("b2b_flags", {4'b0, bus.valid, bus.frame_err, bus.overrun, bus.busy}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
